// File: rtl/uop_bus_latch_bank.sv
// uop_bus_latch_bank
//   A small bank of DEPTH words of WIDTH bits. One word, picked by RADDR, is
//   presented on a tri-state bus Y. A drive FSM waits TURNAROUND bus-release
//   cycles after an output-enable request before it drives the bus. It lets go
//   of the bus combinationally as soon as OE drops (break-before-make).
//
// Ports
//   CLK      : clock, rising edge active
//   nRESET   : asynchronous active-low reset (clears words, FSM and counter)
//   D        : write data
//   LE       : load enable; writes D into word WADDR at the rising edge
//   WADDR    : write address
//   RADDR    : read address of the word presented on Y
//   OE       : output-enable request
//   Y        : tri-state bus output, all 'z' when not driving
//   DRIVING  : high exactly when Y is actively driven
module uop_bus_latch_bank #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int TURNAROUND = 1,
  parameter int BYPASS     = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] D,
  input  logic             LE,
  input  logic [AW-1:0]    WADDR,
  input  logic [AW-1:0]    RADDR,
  input  logic             OE,
  output logic [WIDTH-1:0] Y,
  output logic             DRIVING
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // The counter is loaded with TURNAROUND-1 on entry to WAIT, and the FSM
  // leaves WAIT on the cycle it reads zero. Holding OE therefore gives exactly
  // TURNAROUND cycles in WAIT.
  localparam logic [1:0] CNT_INIT = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
  localparam bit         TA_ZERO  = (TURNAROUND == 0);
  localparam bit         BYP_EN   = (BYPASS == 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  state_e           state_q;
  state_e           state_d;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic [WIDTH-1:0] src_s;
  logic             driving_s;

  // Next contents of the storage words: only the addressed word takes D.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (LE && (WADDR == AW'(i))) ? D : mem_q[i];
    end
  end

  // Storage registers. Reset clears every word; LE has no effect during reset.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Source word. With bypass enabled, a same-address write shows through in
  // the same cycle, as a transparent latch would.
  always_comb begin
    src_s = mem_q[RADDR];
    if (BYP_EN && LE && (WADDR == RADDR)) begin
      src_s = D;
    end else begin
      src_s = mem_q[RADDR];
    end
  end

  // Drive FSM next-state and turnaround counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (OE) begin
          if (TA_ZERO) begin
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!OE) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 2'd0) begin
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_DRIVE: begin
        if (OE) begin
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Drive FSM state and counter registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The bus is gated by OE directly, not only by the registered state. This
  // releases the bus in the same cycle OE falls, and reset (which forces IDLE
  // asynchronously) floats it at once.
  assign driving_s = (state_q == ST_DRIVE) && OE;
  assign DRIVING   = driving_s;
  assign Y         = driving_s ? src_s : {WIDTH{1'bz}};

endmodule

// File: tb/tb_uop_bus_latch_bank.sv
module tb_uop_bus_latch_bank;

  localparam int N = 7;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [31:0] d;
  logic [3:0]  waddr;
  logic [3:0]  raddr;
  logic        le [N];
  logic        oe [N];
  wire  [7:0]  y0, y1, y2, y4;
  wire  [0:0]  y3;
  wire  [31:0] y5, y6;
  wire         drv0, drv1, drv2, drv3, drv4, drv5, drv6;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // u0: defaults, u1: no bypass, u2: turnaround 2, u3..u6: parameter sweep
  uop_bus_latch_bank #(.WIDTH(8), .DEPTH(4), .TURNAROUND(1), .BYPASS(1)) u0 (
    .CLK(clk), .nRESET(n_reset), .D(d[7:0]), .LE(le[0]), .WADDR(waddr[1:0]),
    .RADDR(raddr[1:0]), .OE(oe[0]), .Y(y0), .DRIVING(drv0));
  uop_bus_latch_bank #(.WIDTH(8), .DEPTH(4), .TURNAROUND(1), .BYPASS(0)) u1 (
    .CLK(clk), .nRESET(n_reset), .D(d[7:0]), .LE(le[1]), .WADDR(waddr[1:0]),
    .RADDR(raddr[1:0]), .OE(oe[1]), .Y(y1), .DRIVING(drv1));
  uop_bus_latch_bank #(.WIDTH(8), .DEPTH(4), .TURNAROUND(2), .BYPASS(1)) u2 (
    .CLK(clk), .nRESET(n_reset), .D(d[7:0]), .LE(le[2]), .WADDR(waddr[1:0]),
    .RADDR(raddr[1:0]), .OE(oe[2]), .Y(y2), .DRIVING(drv2));
  uop_bus_latch_bank #(.WIDTH(1), .DEPTH(2), .TURNAROUND(0), .BYPASS(1)) u3 (
    .CLK(clk), .nRESET(n_reset), .D(d[0:0]), .LE(le[3]), .WADDR(waddr[0:0]),
    .RADDR(raddr[0:0]), .OE(oe[3]), .Y(y3), .DRIVING(drv3));
  uop_bus_latch_bank #(.WIDTH(8), .DEPTH(16), .TURNAROUND(3), .BYPASS(1)) u4 (
    .CLK(clk), .nRESET(n_reset), .D(d[7:0]), .LE(le[4]), .WADDR(waddr),
    .RADDR(raddr), .OE(oe[4]), .Y(y4), .DRIVING(drv4));
  uop_bus_latch_bank #(.WIDTH(32), .DEPTH(16), .TURNAROUND(0), .BYPASS(1)) u5 (
    .CLK(clk), .nRESET(n_reset), .D(d), .LE(le[5]), .WADDR(waddr),
    .RADDR(raddr), .OE(oe[5]), .Y(y5), .DRIVING(drv5));
  uop_bus_latch_bank #(.WIDTH(32), .DEPTH(2), .TURNAROUND(3), .BYPASS(1)) u6 (
    .CLK(clk), .nRESET(n_reset), .D(d), .LE(le[6]), .WADDR(waddr[0:0]),
    .RADDR(raddr[0:0]), .OE(oe[6]), .Y(y6), .DRIVING(drv6));

  function automatic int wid(input int idx);
    case (idx)
      3:       return 1;
      5, 6:    return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int dep(input int idx);
    case (idx)
      3, 6:    return 2;
      4, 5:    return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int ta(input int idx);
    case (idx)
      2:       return 2;
      3, 5:    return 0;
      4, 6:    return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] mask(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    else return (32'd1 << w) - 32'd1;
  endfunction

  // Floating bus as seen after zero-extension to 32 bits
  function automatic logic [31:0] zval(input int idx);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (i < wid(idx)) ? 1'bz : 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] pat(input int idx, input int a);
    logic [31:0] v;
    v = (32'(a) * 32'h0000_003B) ^ 32'hA5C3_0F96 ^ (32'(idx) << 4);
    return v & mask(wid(idx));
  endfunction

  function automatic logic [31:0] yv(input int idx);
    case (idx)
      0:       return {24'd0, y0};
      1:       return {24'd0, y1};
      2:       return {24'd0, y2};
      3:       return {31'd0, y3};
      4:       return {24'd0, y4};
      5:       return y5;
      6:       return y6;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic dv(input int idx);
    case (idx)
      0:       return drv0;
      1:       return drv1;
      2:       return drv2;
      3:       return drv3;
      4:       return drv4;
      5:       return drv5;
      6:       return drv6;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty: got %h expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One cycle: expect Y and DRIVING of instance idx, sample mid-cycle
  task automatic cyc_io(input int idx, input logic [31:0] yexp, input logic dexp, input string tag);
    sb_push($sformatf("u%0d_y_%s", idx, tag), yexp);
    sb_push($sformatf("u%0d_drv_%s", idx, tag), {31'd0, dexp});
    @(negedge clk);
    sb_pop_check(yv(idx));
    sb_pop_check({31'd0, dv(idx)});
    next_cyc();
  endtask

  // Raise OE from IDLE: one IDLE cycle plus TURNAROUND WAIT cycles float,
  // then the word is driven. OE is left high.
  task automatic req_drive(input int idx, input logic [31:0] expv, input string tag);
    oe[idx] = 1'b1;
    for (int k = 0; k <= ta(idx); k++) begin
      cyc_io(idx, zval(idx), 1'b0, $sformatf("%s_float%0d", tag, k));
    end
    cyc_io(idx, expv & mask(wid(idx)), 1'b1, $sformatf("%s_drive", tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0;
    d       = 32'hFF;
    waddr   = 4'd2;
    raddr   = 4'd2;
    for (int i = 0; i < N; i++) begin
      le[i] = 1'b0;
      oe[i] = 1'b0;
    end
    // LE and OE are asserted during reset and must both be ignored
    le[0] = 1'b1;
    oe[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      sb_push($sformatf("u%0d_rst_y", i), zval(i));
      sb_push($sformatf("u%0d_rst_drv", i), 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      sb_pop_check(yv(i));
      sb_pop_check({31'd0, dv(i)});
    end
    next_cyc();

    // Reset then read word 2 with OE held
    n_reset = 1'b1;
    le[0]   = 1'b0;
    req_drive(0, 32'h00, "rst_read");

    // Release with a write in the same cycle; re-request pays turnaround again
    oe[0] = 1'b0;
    le[0] = 1'b1;
    waddr = 4'd1;
    d     = 32'hA5;
    cyc_io(0, zval(0), 1'b0, "release");
    le[0] = 1'b0;
    raddr = 4'd1;
    req_drive(0, 32'hA5, "write_read");

    // Preload word 3 in u0 and u1 while u0 keeps driving word 1
    le[0] = 1'b1;
    le[1] = 1'b1;
    waddr = 4'd3;
    d     = 32'h11;
    cyc_io(0, 32'hA5, 1'b1, "hold");
    le[0] = 1'b0;
    le[1] = 1'b0;
    raddr = 4'd3;
    cyc_io(0, 32'h11, 1'b1, "raddr_prop");
    req_drive(1, 32'h11, "nobyp_read");

    // Same-address write while both drive: u0 bypasses, u1 shows old word
    le[0] = 1'b1;
    le[1] = 1'b1;
    d     = 32'h3C;
    sb_push("u0_bypass", 32'h3C);
    sb_push("u1_nobypass_old", 32'h11);
    sb_push("u1_drv", 32'd1);
    @(negedge clk);
    sb_pop_check(yv(0));
    sb_pop_check(yv(1));
    sb_pop_check({31'd0, dv(1)});
    next_cyc();
    le[0] = 1'b0;
    le[1] = 1'b0;
    sb_push("u0_after_edge", 32'h3C);
    sb_push("u1_after_edge", 32'h3C);
    @(negedge clk);
    sb_pop_check(yv(0));
    sb_pop_check(yv(1));
    next_cyc();
    le[0] = 1'b1;
    waddr = 4'd2;
    d     = 32'h77;
    cyc_io(0, 32'h3C, 1'b1, "byp_other_addr");
    le[0] = 1'b0;
    oe[1] = 1'b0;
    cyc_io(1, zval(1), 1'b0, "release");

    // TURNAROUND=2: a 2-cycle OE pulse never drives, then full re-request
    le[2] = 1'b1;
    waddr = 4'd0;
    d     = 32'h5A;
    raddr = 4'd0;
    cyc_io(2, zval(2), 1'b0, "preload");
    le[2] = 1'b0;
    oe[2] = 1'b1;
    cyc_io(2, zval(2), 1'b0, "pulse0");
    cyc_io(2, zval(2), 1'b0, "pulse1");
    oe[2] = 1'b0;
    cyc_io(2, zval(2), 1'b0, "pulse_end");
    req_drive(2, 32'h5A, "ta2_read");
    oe[2] = 1'b0;
    cyc_io(2, zval(2), 1'b0, "release");

    // Asynchronous reset pulse between edges while u0 drives 8'hA5
    raddr = 4'd1;
    sb_push("u0_pre_reset", 32'hA5);
    @(negedge clk);
    sb_pop_check(yv(0));
    #2;
    n_reset = 1'b0;
    sb_push("u0_async_rst_y", zval(0));
    sb_push("u0_async_rst_drv", 32'd0);
    #1;
    sb_pop_check(yv(0));
    sb_pop_check({31'd0, dv(0)});
    oe[0] = 1'b0;
    #1;
    n_reset = 1'b1;
    next_cyc();
    req_drive(0, 32'h00, "post_reset");
    oe[0] = 1'b0;

    // Parameter sweep: fill every word, then read each while driving
    for (int idx = 3; idx < N; idx++) begin
      for (int a = 0; a < dep(idx); a++) begin
        le[idx] = 1'b1;
        waddr   = 4'(a);
        d       = pat(idx, a);
        next_cyc();
      end
      le[idx] = 1'b0;
      raddr   = 4'd0;
      req_drive(idx, pat(idx, 0), "sweep");
      for (int a = 1; a < dep(idx); a++) begin
        raddr = 4'(a);
        cyc_io(idx, pat(idx, a), 1'b1, $sformatf("sweep_a%0d", a));
      end
      oe[idx] = 1'b0;
      cyc_io(idx, zval(idx), 1'b0, "sweep_release");
    end

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uop_bus_latch_bank.md
UOP_BUS_LATCH_BANK -- requirements
Module: uop_bus_latch_bank

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of storage words (a power of two, 2..16).
REQ-003 The block SHALL have parameter TURNAROUND, default 1, giving the number of bus-release cycles before driving (0..3).
REQ-004 The block SHALL have parameter BYPASS, default 1, which enables write-through transparency when set to 1.
REQ-005 The block SHALL have derived parameter AW = $clog2(DEPTH), the address width.

Ports (name, direction, width, meaning):
REQ-006 CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-007 nRESET, input, 1: reset, asynchronous and active-low.
REQ-008 D, input, WIDTH: write data.
REQ-009 LE, input, 1: load enable (write strobe).
REQ-010 WADDR, input, AW: write address.
REQ-011 RADDR, input, AW: read address (word presented on Y).
REQ-012 OE, input, 1: output-enable request.
REQ-013 Y, output (tri-state), WIDTH: bus output, all bits 'z' when not driving.
REQ-014 DRIVING, output, 1: high exactly when Y is actively driven.

Function
REQ-015 Write: at a rising CLK edge with LE=1, mem[WADDR] SHALL take D. With LE=0, mem SHALL hold.
REQ-016 Source word: SRC = mem[RADDR], combinational from stored contents.
REQ-017 When BYPASS=1, LE=1 and WADDR==RADDR, SRC SHALL equal D in the same cycle (latch-style transparency).
REQ-018 When BYPASS=0, a same-address write SHALL appear on SRC only after the write edge.
REQ-019 Drive FSM states SHALL be IDLE, WAIT and DRIVE, with a 2-bit counter CNT.
REQ-020 IDLE with OE=1 at an edge: the FSM SHALL go to DRIVE if TURNAROUND=0; otherwise it SHALL go to WAIT with CNT=TURNAROUND-1.
REQ-021 IDLE with OE=0: the FSM SHALL stay in IDLE.
REQ-022 WAIT with OE=0 at an edge: the FSM SHALL go to IDLE.
REQ-023 WAIT with OE=1: if CNT==0 the FSM SHALL go to DRIVE; otherwise it SHALL decrement CNT.
REQ-024 With OE held high, the FSM SHALL spend exactly TURNAROUND cycles in WAIT.
REQ-025 DRIVE with OE=0 at an edge: the FSM SHALL go to IDLE. With OE=1 it SHALL stay in DRIVE.
REQ-026 Y SHALL equal SRC iff state==DRIVE and OE==1; otherwise Y SHALL be all-'z'.
REQ-027 Release SHALL be combinational (break-before-make): OE falling in DRIVE floats Y in the same cycle, before the FSM reaches IDLE.
REQ-028 DRIVING SHALL equal (state==DRIVE && OE), combinational, so it is consistent with Y at all times.
REQ-029 While in DRIVE, changes to RADDR or to mem SHALL propagate to Y with no added latency.
REQ-030 OE pulse shorter than TURNAROUND+1 cycles: Y SHALL never be driven.
REQ-031 A re-request after release SHALL pay the full TURNAROUND again.
REQ-032 Writes and the FSM SHALL be independent; LE SHALL be accepted in every state.

Reset
REQ-033 While nRESET=0, asynchronously: all mem words SHALL be 0, the state IDLE, CNT 0, Y all-'z' and DRIVING 0.
REQ-034 Assertion of nRESET mid-DRIVE SHALL float Y immediately, without waiting for a clock edge.
REQ-035 After deassertion, the first OE=1 edge SHALL follow the IDLE transition of REQ-020.
REQ-036 LE SHALL be ignored while nRESET=0.

Verification
REQ-037 Reset then read: nRESET low then high; OE=1 held; RADDR=2 -> Y='z' for 1 cycle (TURNAROUND=1), then Y=8'h00 and DRIVING=1.
REQ-038 Write then drive: LE=1, WADDR=1, D=8'hA5 for one edge; RADDR=1, OE=1 -> Y='z' for TURNAROUND cycles, then Y=8'hA5.
REQ-039 Bypass: in DRIVE with RADDR=3, LE=1, WADDR=3, D=8'h3C -> Y=8'h3C in the same cycle with BYPASS=1; with BYPASS=0, Y keeps the old word until after the edge.
REQ-040 Short OE and release: with TURNAROUND=2, a 2-cycle OE pulse -> Y never driven. In DRIVE, OE falls -> Y='z' and DRIVING=0 in the same cycle; the state is IDLE at the next edge.
REQ-041 Async reset mid-drive: in DRIVE with Y=8'hA5, pulse nRESET low between edges -> Y='z' at once and the next read returns 8'h00.
REQ-042 Parameter sweep: WIDTH in {1,8,32}, DEPTH in {2,16}, TURNAROUND in {0,3} -> write and read every address; WAIT length equals TURNAROUND cycles in each configuration.
